// File: rtl/ps2_scancode_monitor_if.sv
// rtl/ps2_scancode_monitor_if.sv - byte/strobe input and display-side outputs of the scancode monitor
interface ps2_scancode_monitor_if;
    logic [7:0]  scancode;
    logic        scancode_valid;
    logic        freeze;
    logic [15:0] disp_value;
    logic        scan_clk;
    logic        key_event;
    logic [7:0]  make_count;
    logic        prefix_err;

    // PS/2 receiver side: drives bytes and freeze, observes the results
    modport master (
        output scancode,
        output scancode_valid,
        output freeze,
        input  disp_value,
        input  scan_clk,
        input  key_event,
        input  make_count,
        input  prefix_err
    );

    // monitor side
    modport slave (
        input  scancode,
        input  scancode_valid,
        input  freeze,
        output disp_value,
        output scan_clk,
        output key_event,
        output make_count,
        output prefix_err
    );
endinterface

// File: rtl/ps2_scancode_monitor.sv
// rtl/ps2_scancode_monitor.sv - PS/2 E0/F0 prefix parser, display word builder and scan clock divider
module ps2_scancode_monitor #(
    parameter int SCAN_DIV   = 16384,
    parameter int PREFIX_TMO = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_scancode_monitor_if.slave   bus
);

    localparam int HALF = SCAN_DIV / 2;
    localparam int SW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int TW   = $clog2(PREFIX_TMO + 1);

    localparam logic [SW-1:0] HALF_LAST = SW'(HALF - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(PREFIX_TMO - 1);

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GOT_E0,
        S_GOT_F0,
        S_GOT_E0F0
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            commit;
    logic            ext;
    logic            brk;
    logic            timeout;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   scan_cnt;
    logic            scan_q;
    logic [15:0]     disp_q;
    logic            key_event_q;
    logic [7:0]      make_count_q;
    logic            prefix_err_q;

    logic            is_e0;
    logic            is_f0;

    assign is_e0 = (bus.scancode == CODE_E0);
    assign is_f0 = (bus.scancode == CODE_F0);

    // parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decode; a strobe always takes priority over the prefix timeout
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        ext        = 1'b0;
        brk        = 1'b0;
        timeout    = 1'b0;
        if (bus.scancode_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_e0)      next_state = S_GOT_E0;
                    else if (is_f0) next_state = S_GOT_F0;
                    else begin
                        commit     = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_GOT_E0: begin
                    if (is_e0)      next_state = S_GOT_E0;
                    else if (is_f0) next_state = S_GOT_E0F0;
                    else begin
                        commit     = 1'b1;
                        ext        = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_GOT_F0: begin
                    if (is_f0)      next_state = S_GOT_F0;
                    else if (is_e0) next_state = S_GOT_E0F0;
                    else begin
                        commit     = 1'b1;
                        brk        = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: begin
                    if (is_e0 || is_f0) next_state = S_GOT_E0F0;
                    else begin
                        commit     = 1'b1;
                        ext        = 1'b1;
                        brk        = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            endcase
        end else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
            timeout    = 1'b1;
            next_state = S_IDLE;
        end
    end

    // idle-cycle timer while a prefix is pending; cleared by any strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (bus.scancode_valid || state == S_IDLE || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // commit side effects: event pulse, display word, make counter, sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q       <= 16'h0000;
            key_event_q  <= 1'b0;
            make_count_q <= 8'h00;
            prefix_err_q <= 1'b0;
        end else begin
            key_event_q <= commit;
            if (commit && !bus.freeze) begin
                disp_q <= {(ext ? 4'hE : 4'h0), (brk ? 4'hF : 4'h0), bus.scancode};
            end
            if (commit && !brk) begin
                make_count_q <= make_count_q + 8'h01;
            end
            if (timeout) begin
                prefix_err_q <= 1'b1;
            end
        end
    end

    // free-running half-period divider for the display anode scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_q   <= 1'b0;
        end else if (scan_cnt == HALF_LAST) begin
            scan_cnt <= '0;
            scan_q   <= ~scan_q;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign bus.disp_value = disp_q;
    assign bus.key_event  = key_event_q;
    assign bus.make_count = make_count_q;
    assign bus.prefix_err = prefix_err_q;
    assign bus.scan_clk   = scan_q;

endmodule
